player_controller: RTL and testbench
====================================

// Module: player_controller
// PURPOSE
//  Parametrised player entity controller for the TinyTapeStation game grid.
//  Converts controller buttons into held-repeat movement, timed sword attacks with cooldown, and hit
//  handling (health, knockback, invulnerability). Runs once per frame on frame_clk; feeds the
//  renderer/collision logic.
//  Entity word: [13:10] entityId, [9:8] orient (00 up, 01 right, 10 down, 11 left), [7:4] X, [3:0] Y.
// PARAMETERS
//  X_MIN          1   leftmost legal player column
//  X_MAX          14  rightmost legal player column
//  Y_MIN          2   top legal row
//  Y_MAX          10  bottom legal row
//  START_X        8   reset column
//  START_Y        2   reset row
//  MAX_HEALTH     3   reset/max hearts
//  MOVE_PERIOD    4   frames between repeat steps while a direction is held (>=1)
//  ATTACK_FRAMES  8   frames sword stays visible (>=1)
//  COOLDOWN_FRAMES 4  frames after an attack before the next one may start
//  INVULN_FRAMES  30  frames hits are ignored after an accepted hit
//  Constraint: 0 <= X_MIN <= START_X <= X_MAX <= 15. Same ordering for Y.
// PORTS
//  frame_clk      in   1   frame clock; all logic on posedge
//  rst            in   1   synchronous, active-high reset
//  A, B           in   1   attack buttons (OR-ed)
//  up,down,left,right in 1 direction buttons
//  hit            in   1   collision logic: player touched by hazard this frame
//  hit_dir        in   2   direction the hazard came FROM (orient encoding)
//  player         out  14  player entity word, id 4'b0010
//  sword          out  14  sword entity word, id 4'b0001 when visible
//  player_health  out  HW  hearts, HW = $clog2(MAX_HEALTH+1)
//  invulnerable   out  1   1 while invulnerability timer is nonzero
//  game_over      out  1   1 in DEAD
// BEHAVIOUR
//  - Reset: player = {0010,01,START_X,START_Y}; sword = HIDDEN = 14'b1111_01_0000_0000.
//    Health = MAX_HEALTH; invulnerable = 0; game_over = 0; state IDLE; all counters 0.
//  - All outputs are registered and update on the posedge that samples the inputs.
//  - Direction is valid only if exactly one of up/down/left/right is high; otherwise none.
//  - Attack request = rising edge of (A|B), registered previous value, with cooldown == 0.
//  - States: IDLE, MOVE, ATTACK, DEAD.
//  - IDLE: a request goes to ATTACK. Else a valid dir steps immediately and goes to MOVE,
//    with move_cnt = MOVE_PERIOD-1.
//  - MOVE: a valid dir always updates orient. Step when move_cnt == 0 and reload it;
//    otherwise decrement. No dir returns to IDLE. An attack request goes to ATTACK, with
//    priority over stepping.
//  - Step: move 1 tile in dir, clamped to [MIN,MAX]. At a border, orient still updates and
//    the position holds.
//  - ATTACK entry: orient = valid dir, else the stored orient. The target is the tile in front.
//    If the target is inside the legal range, sword = {0001,orient,target}; else sword stays
//    HIDDEN, but the attack timing still runs. attack_cnt = ATTACK_FRAMES-1. Position is frozen.
//  - ATTACK: when attack_cnt == 0, set sword = HIDDEN, cooldown = COOLDOWN_FRAMES, go to IDLE.
//    Otherwise decrement.
//  - Cooldown and invuln counters decrement once per frame while nonzero, outside ATTACK.
//    The invuln counter also decrements in ATTACK.
//  - Accepted hit: hit && invuln == 0 && state != DEAD. Health decrements and
//    invuln = INVULN_FRAMES.
//    - Knockback: 1 tile opposite to hit_dir, clamped. Orient is unchanged.
//    - Any MOVE/ATTACK is aborted: state IDLE, sword HIDDEN, cooldown = 0.
//    - A hit has priority over all same-frame button activity.
//  - If health reaches 0 on a hit: go to DEAD (no knockback), game_over = 1, sword HIDDEN.
//    All inputs are ignored until rst.
//  - Health never underflows and never increases; rst mid-operation restores reset values on
//    that edge.
// TESTING
//  - Reset: assert rst 1 frame -> player=14'b0010_01_1000_0010, sword=14'b1111_01_0000_0000,
//    health=3, game_over=0.
//  - Hold right 9 frames from X=8 -> X=9 after frame 1, 10 after frame 5, 11 after frame 9;
//    orient=01.
//  - Hold up at Y=2 -> Y stays 2, orient=00. Hold left from X=1 -> X stays 1.
//  - At (8,5) facing right, pulse A -> sword=14'b0001_01_1001_0101 for 8 frames, then HIDDEN.
//    A re-pulse during cooldown -> ignored. A held high -> single attack only.
//  - hit=1, hit_dir=01 at (8,5) -> health=2, X=7, invulnerable=1 for 30 frames.
//    A second hit in that window -> ignored.
//  - Hit during ATTACK -> sword HIDDEN, IDLE. A third accepted hit -> health=0, game_over=1,
//    buttons have no effect; rst recovers.

Source files
------------

// File: rtl/player_controller.sv
// Player entity controller: held-repeat movement, timed sword attacks with cooldown,
// and hit handling (health, knockback, invulnerability), advanced once per frame.
module player_controller #(
    parameter int X_MIN           = 1,
    parameter int X_MAX           = 14,
    parameter int Y_MIN           = 2,
    parameter int Y_MAX           = 10,
    parameter int START_X         = 8,
    parameter int START_Y         = 2,
    parameter int MAX_HEALTH      = 3,
    parameter int MOVE_PERIOD     = 4,
    parameter int ATTACK_FRAMES   = 8,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int INVULN_FRAMES   = 30
) (
    input  logic                                frame_clk,
    input  logic                                rst,
    input  logic                                A,
    input  logic                                B,
    input  logic                                up,
    input  logic                                down,
    input  logic                                left,
    input  logic                                right,
    input  logic                                hit,
    input  logic [1:0]                          hit_dir,
    output logic [13:0]                         player,
    output logic [13:0]                         sword,
    output logic [$clog2(MAX_HEALTH+1)-1:0]     player_health,
    output logic                                invulnerable,
    output logic                                game_over
);

    localparam int HW = $clog2(MAX_HEALTH + 1);
    localparam int MW = $clog2(MOVE_PERIOD) + 1;
    localparam int AW = $clog2(ATTACK_FRAMES) + 1;
    localparam int CW = $clog2(COOLDOWN_FRAMES) + 1;
    localparam int IW = $clog2(INVULN_FRAMES) + 1;
    localparam logic [13:0] SWORD_HIDDEN = 14'b1111_01_0000_0000;

    typedef enum logic [1:0] {IDLE, MOVE, ATTACK, DEAD} state_t;

    state_t          state_q, state_d;
    logic [7:0]      pos_q, pos_d;
    logic [1:0]      orient_q, orient_d;
    logic [13:0]     sword_q, sword_d;
    logic [HW-1:0]   health_q, health_d;
    logic [MW-1:0]   move_cnt_q, move_cnt_d;
    logic [AW-1:0]   attack_cnt_q, attack_cnt_d;
    logic [CW-1:0]   cooldown_q, cooldown_d;
    logic [IW-1:0]   invuln_q, invuln_d;
    logic            btn_prev_q, btn_prev_d;

    logic            btn;
    logic            dir_valid;
    logic [1:0]      dir;
    logic            attack_req;
    logic            hit_ok;
    logic [1:0]      attack_orient;
    logic [7:0]      target;

    // One tile in direction d, clamped to the legal playfield.
    function automatic logic [7:0] step_pos(input logic [7:0] pos, input logic [1:0] d);
        logic [3:0] x;
        logic [3:0] y;
        x = pos[7:4];
        y = pos[3:0];
        case (d)
            2'b00:   if (y > 4'(Y_MIN)) y = y - 4'd1;
            2'b01:   if (x < 4'(X_MAX)) x = x + 4'd1;
            2'b10:   if (y < 4'(Y_MAX)) y = y + 4'd1;
            default: if (x > 4'(X_MIN)) x = x - 4'd1;
        endcase
        return {x, y};
    endfunction

    always_comb begin
        btn           = A | B;
        dir_valid     = $onehot({up, down, left, right});
        dir           = up ? 2'b00 : right ? 2'b01 : down ? 2'b10 : 2'b11;
        attack_req    = btn & ~btn_prev_q & (cooldown_q == '0);
        hit_ok        = hit & (invuln_q == '0) & (state_q != DEAD);
        attack_orient = dir_valid ? dir : orient_q;
        // The player is always on a legal tile, so a clamped step that does not move
        // means the tile in front is off the playfield.
        target        = step_pos(pos_q, attack_orient);

        state_d      = state_q;
        pos_d        = pos_q;
        orient_d     = orient_q;
        sword_d      = sword_q;
        health_d     = health_q;
        move_cnt_d   = move_cnt_q;
        attack_cnt_d = attack_cnt_q;
        cooldown_d   = cooldown_q;
        invuln_d     = invuln_q;
        btn_prev_d   = btn;

        if (invuln_q != '0) invuln_d = invuln_q - 1'b1;
        if (cooldown_q != '0 && state_q != ATTACK) cooldown_d = cooldown_q - 1'b1;

        if (hit_ok) begin
            if (health_q != '0) health_d = health_q - 1'b1;
            invuln_d     = IW'(INVULN_FRAMES);
            cooldown_d   = '0;
            sword_d      = SWORD_HIDDEN;
            move_cnt_d   = '0;
            attack_cnt_d = '0;
            if (health_q <= HW'(1)) begin
                state_d = DEAD;
            end else begin
                state_d = IDLE;
                pos_d   = step_pos(pos_q, hit_dir ^ 2'b10);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!attack_req && dir_valid) begin
                        orient_d   = dir;
                        pos_d      = step_pos(pos_q, dir);
                        move_cnt_d = MW'(MOVE_PERIOD - 1);
                        state_d    = MOVE;
                    end
                end
                MOVE: begin
                    if (!attack_req) begin
                        if (dir_valid) begin
                            orient_d = dir;
                            if (move_cnt_q == '0) begin
                                pos_d      = step_pos(pos_q, dir);
                                move_cnt_d = MW'(MOVE_PERIOD - 1);
                            end else begin
                                move_cnt_d = move_cnt_q - 1'b1;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ATTACK: begin
                    if (attack_cnt_q == '0) begin
                        sword_d    = SWORD_HIDDEN;
                        cooldown_d = CW'(COOLDOWN_FRAMES);
                        state_d    = IDLE;
                    end else begin
                        attack_cnt_d = attack_cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase

            if (attack_req && (state_q == IDLE || state_q == MOVE)) begin
                state_d      = ATTACK;
                orient_d     = attack_orient;
                sword_d      = (target != pos_q) ? {4'b0001, attack_orient, target} : SWORD_HIDDEN;
                attack_cnt_d = AW'(ATTACK_FRAMES - 1);
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pos_q        <= {4'(START_X), 4'(START_Y)};
            orient_q     <= 2'b01;
            sword_q      <= SWORD_HIDDEN;
            health_q     <= HW'(MAX_HEALTH);
            move_cnt_q   <= '0;
            attack_cnt_q <= '0;
            cooldown_q   <= '0;
            invuln_q     <= '0;
            btn_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            orient_q     <= orient_d;
            sword_q      <= sword_d;
            health_q     <= health_d;
            move_cnt_q   <= move_cnt_d;
            attack_cnt_q <= attack_cnt_d;
            cooldown_q   <= cooldown_d;
            invuln_q     <= invuln_d;
            btn_prev_q   <= btn_prev_d;
        end
    end

    assign player        = {4'b0010, orient_q, pos_q};
    assign sword         = sword_q;
    assign player_health = health_q;
    assign invulnerable  = (invuln_q != '0);
    assign game_over     = (state_q == DEAD);

endmodule

// File: tb/tb_player_controller.sv
// Scoreboarded bench for player_controller: a frame-level behavioural model queues the
// expected outputs per frame, and a monitor compares them against the DUT.
module tb_player_controller;

    localparam int X_MIN = 1, X_MAX = 14, Y_MIN = 2, Y_MAX = 10;
    localparam int START_X = 8, START_Y = 2, MAX_HEALTH = 3;
    localparam int MOVE_PERIOD = 4, ATTACK_FRAMES = 8, COOLDOWN_FRAMES = 4, INVULN_FRAMES = 30;
    localparam logic [13:0] HIDDEN = 14'b1111_01_0000_0000;

    logic        frame_clk = 1'b0;
    logic        rst = 1'b0, A = 1'b0, B = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, hit = 1'b0;
    logic [1:0]  hit_dir = 2'b00;
    logic [13:0] player, sword;
    logic [1:0]  player_health;
    logic        invulnerable, game_over;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 frame_clk = ~frame_clk;

    player_controller #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .START_X(START_X), .START_Y(START_Y), .MAX_HEALTH(MAX_HEALTH),
        .MOVE_PERIOD(MOVE_PERIOD), .ATTACK_FRAMES(ATTACK_FRAMES),
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES), .INVULN_FRAMES(INVULN_FRAMES)
    ) dut (
        .frame_clk(frame_clk), .rst(rst), .A(A), .B(B),
        .up(up), .down(down), .left(left), .right(right),
        .hit(hit), .hit_dir(hit_dir),
        .player(player), .sword(sword), .player_health(player_health),
        .invulnerable(invulnerable), .game_over(game_over)
    );

    typedef struct {
        logic [13:0] p;
        logic [13:0] s;
        int          hp;
        bit          inv;
        bit          go;
    } exp_t;

    exp_t sb[$];

    // Reference model: modes 0 idle, 1 walking, 2 swinging, 3 dead.
    int m_x, m_y, m_or, m_hp, m_mode, m_hold, m_left, m_cool, m_inv, m_tx, m_ty;
    bit m_svis, m_prev;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int dxo(input int o);
        return (o == 1) ? 1 : (o == 3) ? -1 : 0;
    endfunction

    function automatic int dyo(input int o);
        return (o == 0) ? -1 : (o == 2) ? 1 : 0;
    endfunction

    task automatic m_step(input int o);
        m_x = clampi(m_x + dxo(o), X_MIN, X_MAX);
        m_y = clampi(m_y + dyo(o), Y_MIN, Y_MAX);
    endtask

    task automatic m_start_attack(input bit dv, input int dir);
        if (dv) m_or = dir;
        m_tx   = m_x + dxo(m_or);
        m_ty   = m_y + dyo(m_or);
        m_svis = (m_tx >= X_MIN && m_tx <= X_MAX && m_ty >= Y_MIN && m_ty <= Y_MAX);
        m_left = ATTACK_FRAMES;
        m_mode = 2;
    endtask

    task automatic model_frame(input bit r, input bit a, input bit b, input bit iu, input bit id,
                               input bit il, input bit ir, input bit h, input bit [1:0] hd);
        int  nd, dir, inv_was, cool_was, kd;
        bit  press, req, dv;
        if (r) begin
            m_x = START_X; m_y = START_Y; m_or = 1; m_hp = MAX_HEALTH; m_mode = 0;
            m_hold = 0; m_left = 0; m_cool = 0; m_inv = 0; m_svis = 0; m_prev = 0;
            return;
        end
        press    = (a | b) && !m_prev;
        m_prev   = a | b;
        nd       = int'(iu) + int'(id) + int'(il) + int'(ir);
        dv       = (nd == 1);
        dir      = iu ? 0 : ir ? 1 : id ? 2 : 3;
        inv_was  = m_inv;
        cool_was = m_cool;
        req      = press && (cool_was == 0);
        if (m_inv > 0) m_inv--;
        if (m_cool > 0 && m_mode != 2) m_cool--;
        if (h && inv_was == 0 && m_mode != 3) begin
            m_hp--;
            m_inv  = INVULN_FRAMES;
            m_cool = 0;
            m_svis = 0;
            if (m_hp == 0) begin
                m_mode = 3;
            end else begin
                m_mode = 0;
                kd = int'(hd ^ 2'b10);
                m_step(kd);
            end
        end else begin
            case (m_mode)
                0: begin
                    if (req) m_start_attack(dv, dir);
                    else if (dv) begin
                        m_or = dir; m_step(dir); m_mode = 1; m_hold = 0;
                    end
                end
                1: begin
                    if (req) m_start_attack(dv, dir);
                    else if (dv) begin
                        m_or = dir;
                        m_hold++;
                        if (m_hold % MOVE_PERIOD == 0) m_step(dir);
                    end else m_mode = 0;
                end
                2: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 0; m_svis = 0; m_cool = COOLDOWN_FRAMES;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.p   = {4'b0010, 2'(m_or), 4'(m_x), 4'(m_y)};
        e.s   = (m_mode == 2 && m_svis) ? {4'b0001, 2'(m_or), 4'(m_tx), 4'(m_ty)} : HIDDEN;
        e.hp  = m_hp;
        e.inv = (m_inv > 0);
        e.go  = (m_mode == 3);
        return e;
    endfunction

    task automatic drive_frame(input bit r, input bit a, input bit b, input bit iu, input bit id,
                               input bit il, input bit ir, input bit h, input bit [1:0] hd);
        @(negedge frame_clk);
        rst = r; A = a; B = b; up = iu; down = id; left = il; right = ir; hit = h; hit_dir = hd;
        @(posedge frame_clk);
        model_frame(r, a, b, iu, id, il, ir, h, hd);
        sb.push_back(model_out());
    endtask

    task automatic idle(input int n);
        repeat (n) drive_frame(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    endtask

    // dir: 0 up, 1 right, 2 down, 3 left
    task automatic hold_dir(input int dir, input int n);
        repeat (n) drive_frame(0, 0, 0, dir == 0, dir == 2, dir == 3, dir == 1, 0, 2'b00);
    endtask

    task automatic pulse_dir(input int dir, input int n);
        repeat (n) begin
            hold_dir(dir, 1);
            idle(1);
        end
    endtask

    task automatic do_hit(input bit [1:0] hd);
        drive_frame(0, 0, 0, 0, 0, 0, 0, 1, hd);
    endtask

    task automatic press_a(input int n);
        repeat (n) drive_frame(0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("player", 32'(player), 32'(e.p));
                chk("sword", 32'(sword), 32'(e.s));
                chk("health", 32'(player_health), 32'(e.hp));
                chk("invulnerable", 32'(invulnerable), 32'(e.inv));
                chk("game_over", 32'(game_over), 32'(e.go));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got=%0t expected<500000", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin : stim
        drive_frame(1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        #2;
        chk("reset_player", 32'(player), 32'(14'b0010_01_1000_0010));
        chk("reset_sword", 32'(sword), 32'(HIDDEN));
        chk("reset_health", 32'(player_health), 32'd3);
        chk("reset_game_over", 32'(game_over), 32'd0);

        hold_dir(1, 1); #2 chk("right_f1_x", 32'(player[7:4]), 32'd9);
        hold_dir(1, 4); #2 chk("right_f5_x", 32'(player[7:4]), 32'd10);
        hold_dir(1, 4); #2 chk("right_f9_x", 32'(player[7:4]), 32'd11);
        chk("right_orient", 32'(player[9:8]), 32'd1);
        idle(1);

        hold_dir(0, 3); #2 chk("up_border_y", 32'(player[3:0]), 32'd2);
        chk("up_border_orient", 32'(player[9:8]), 32'd0);
        idle(1);

        hold_dir(3, 45); #2 chk("left_border_x", 32'(player[7:4]), 32'd1);
        idle(1);

        pulse_dir(1, 7);
        pulse_dir(2, 3);
        pulse_dir(3, 1);
        pulse_dir(1, 1);
        #2 chk("pos_8_5", 32'(player), 32'(14'b0010_01_1000_0101));

        press_a(1); #2 chk("sword_on", 32'(sword), 32'(14'b0001_01_1001_0101));
        idle(7);    #2 chk("sword_last", 32'(sword), 32'(14'b0001_01_1001_0101));
        idle(1);    #2 chk("sword_off", 32'(sword), 32'(HIDDEN));
        press_a(1); #2 chk("cooldown_ignored", 32'(sword), 32'(HIDDEN));
        idle(6);
        press_a(20); #2 chk("held_single_attack", 32'(sword), 32'(HIDDEN));
        idle(2);

        do_hit(2'b01); #2 chk("hit_health", 32'(player_health), 32'd2);
        chk("hit_knock_x", 32'(player[7:4]), 32'd7);
        chk("hit_invuln", 32'(invulnerable), 32'd1);
        idle(4);
        do_hit(2'b10); #2 chk("hit_ignored", 32'(player_health), 32'd2);
        idle(24); #2 chk("invuln_still", 32'(invulnerable), 32'd1);
        idle(1);  #2 chk("invuln_over", 32'(invulnerable), 32'd0);

        press_a(1);
        do_hit(2'b00); #2 chk("hit_in_attack_sword", 32'(sword), 32'(HIDDEN));
        chk("hit_in_attack_health", 32'(player_health), 32'd1);
        idle(30);
        do_hit(2'b11); #2 chk("dead_health", 32'(player_health), 32'd0);
        chk("dead_game_over", 32'(game_over), 32'd1);
        repeat (12) drive_frame(0, $urandom_range(0, 1) == 0, 0, 1'($urandom), 1'($urandom),
                                1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
        #2 chk("dead_frozen_health", 32'(player_health), 32'd0);
        drive_frame(1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        #2 chk("recover_player", 32'(player), 32'(14'b0010_01_1000_0010));
        chk("recover_game_over", 32'(game_over), 32'd0);

        for (int seg = 0; seg < 6; seg++) begin
            drive_frame(1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
            for (int f = 0; f < 300; f++) begin
                drive_frame($urandom_range(0, 299) == 0,
                            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                            $urandom_range(0, 39) == 0, 2'($urandom));
            end
        end

        idle(1);
        #3 chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
